// File: rtl/usb_cam_pkg.sv
// Shared types and helpers for the camera-to-USB line path: camera select, arbiter
// states, line length helper and the command bytes shared with the USB writer FSM.
package usb_cam_pkg;

    typedef enum logic {
        CAM_R = 1'b0,
        CAM_L = 1'b1
    } cam_sel_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ARB    = 3'd1,
        ST_SWITCH = 3'd2,
        ST_OFFER  = 3'd3,
        ST_XFER   = 3'd4
    } arb_state_e;

    localparam logic [7:0] CMD_LINE_R    = 8'hA0;
    localparam logic [7:0] CMD_LINE_L    = 8'hA1;
    localparam logic [7:0] CMD_FRAME_END = 8'hAF;

    // 16-bit words per line, one of which is the line header.
    function automatic int line_words(input int im_x, input int color_mode);
        return (color_mode * im_x + 2) / 2;
    endfunction

endpackage

// File: rtl/cam_line_counter.sv
// Per-camera line index counter: wraps at IM_Y-1 and emits a one-cycle registered wrap
// pulse together with the wrapped count; clr has priority over inc.
module cam_line_counter #(
    parameter int IM_Y = 720
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        inc,
    output logic [15:0] cnt,
    output logic        wrap
);

    logic [15:0] r_cnt;
    logic        r_wrap;

    // Line count and frame wrap pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= 16'd0;
            r_wrap <= 1'b0;
        end else if (clr) begin
            r_cnt  <= 16'd0;
            r_wrap <= 1'b0;
        end else if (inc) begin
            if (r_cnt == 16'(IM_Y - 1)) begin
                r_cnt  <= 16'd0;
                r_wrap <= 1'b1;
            end else begin
                r_cnt  <= r_cnt + 16'd1;
                r_wrap <= 1'b0;
            end
        end else begin
            r_wrap <= 1'b0;
        end
    end

    assign cnt  = r_cnt;
    assign wrap = r_wrap;

endmodule

// File: rtl/usb_line_arbiter.sv
// Grants whole camera lines to the USB writer, choosing by FIFO fill level with a
// DMA-address switch guard. Define LOCKSTEP_EN for strict R,L,R,L alternation.
module usb_line_arbiter
    import usb_cam_pkg::*;
#(
    parameter  int IM_X       = 1280,
    parameter  int IM_Y       = 720,
    parameter  int COLOR_MODE = 2,
    parameter  int MAX_CONSEC = 2,
    parameter  int SW_LAT     = 6,
    localparam int WORDS      = line_words(IM_X, COLOR_MODE),
    localparam int XW         = $clog2(2 * WORDS)
) (
    input  logic          USB_CLK,
    input  logic          rst_n,
    input  logic          start_stream,
    input  logic [XW-1:0] usedw_r,
    input  logic [XW-1:0] usedw_l,
    input  logic          dma_ready,
    output logic          grant_valid,
    output logic          grant_sel,
    input  logic          grant_ack,
    input  logic          line_done,
    output logic [15:0]   line_num,
    output logic          frame_end,
    output logic          busy
);

    localparam int CW = $clog2(MAX_CONSEC + 1);
    localparam int SW = $clog2(SW_LAT + 1);
    localparam logic [XW-1:0] RDY_LVL = XW'(WORDS - 1);

    arb_state_e  r_state;
    logic        r_grant_valid;
    logic        r_grant_sel;
    logic        r_busy;
    logic [15:0] r_line_num;
    logic        r_last_sel;
    logic [CW-1:0] r_consec;
    logic [SW-1:0] r_sw_cnt;
`ifdef LOCKSTEP_EN
    logic        r_due;
`endif

    logic        w_rdy_r;
    logic        w_rdy_l;
    logic        w_cand;
    logic        w_cand_ok;
    logic        w_done;
    logic        w_clr;
    logic [15:0] w_cnt_r;
    logic [15:0] w_cnt_l;
    logic        w_wrap_r;
    logic        w_wrap_l;

    assign w_rdy_r = (usedw_r >= RDY_LVL);
    assign w_rdy_l = (usedw_l >= RDY_LVL);
    // A stop in the same cycle as line_done suppresses the count.
    assign w_clr   = !start_stream;
    assign w_done  = (r_state == ST_XFER) && line_done && start_stream;

    cam_line_counter #(.IM_Y(IM_Y)) u_cnt_r (
        .clk   (USB_CLK),
        .rst_n (rst_n),
        .clr   (w_clr),
        .inc   (w_done && (r_grant_sel == CAM_R)),
        .cnt   (w_cnt_r),
        .wrap  (w_wrap_r)
    );

    cam_line_counter #(.IM_Y(IM_Y)) u_cnt_l (
        .clk   (USB_CLK),
        .rst_n (rst_n),
        .clr   (w_clr),
        .inc   (w_done && (r_grant_sel == CAM_L)),
        .cnt   (w_cnt_l),
        .wrap  (w_wrap_l)
    );

    // Next-camera candidate from readiness and fill levels.
    always_comb begin
        w_cand    = r_grant_sel;
        w_cand_ok = 1'b0;
`ifdef LOCKSTEP_EN
        w_cand    = r_due;
        w_cand_ok = r_due ? w_rdy_l : w_rdy_r;
`else
        if (w_rdy_r && w_rdy_l) begin
            w_cand_ok = 1'b1;
            if (r_consec == CW'(MAX_CONSEC)) begin
                w_cand = ~r_last_sel;
            end else if (usedw_r > usedw_l) begin
                w_cand = CAM_R;
            end else if (usedw_l > usedw_r) begin
                w_cand = CAM_L;
            end else begin
                w_cand = ~r_last_sel;
            end
        end else if (w_rdy_r) begin
            w_cand    = CAM_R;
            w_cand_ok = 1'b1;
        end else if (w_rdy_l) begin
            w_cand    = CAM_L;
            w_cand_ok = 1'b1;
        end else begin
            w_cand    = r_grant_sel;
            w_cand_ok = 1'b0;
        end
`endif
    end

    // Arbiter FSM with registered grant, busy and line number outputs.
    always_ff @(posedge USB_CLK or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_grant_valid <= 1'b0;
            r_grant_sel   <= 1'b0;
            r_busy        <= 1'b0;
            r_line_num    <= 16'd0;
            r_last_sel    <= 1'b0;
            r_consec      <= '0;
            r_sw_cnt      <= '0;
`ifdef LOCKSTEP_EN
            r_due         <= 1'b0;
`endif
        end else if (!start_stream) begin
            // grant_sel and last_sel deliberately hold across a stop.
            r_state       <= ST_IDLE;
            r_grant_valid <= 1'b0;
            r_busy        <= 1'b0;
            r_line_num    <= 16'd0;
            r_consec      <= '0;
            r_sw_cnt      <= '0;
`ifdef LOCKSTEP_EN
            r_due         <= 1'b0;
`endif
        end else begin
            r_line_num <= r_grant_sel ? w_cnt_l : w_cnt_r;
            case (r_state)
                ST_IDLE: begin
                    r_state <= ST_ARB;
                end
                ST_ARB: begin
                    if (dma_ready && w_cand_ok) begin
                        if (w_cand != r_grant_sel) begin
                            r_state     <= ST_SWITCH;
                            r_grant_sel <= w_cand;
                            r_sw_cnt    <= '0;
                        end else begin
                            r_state       <= ST_OFFER;
                            r_grant_valid <= 1'b1;
                        end
                    end else begin
                        r_state <= ST_ARB;
                    end
                end
                ST_SWITCH: begin
                    if (r_sw_cnt == SW'(SW_LAT - 1)) begin
                        if (dma_ready) begin
                            r_state       <= ST_OFFER;
                            r_grant_valid <= 1'b1;
                        end else begin
                            r_state <= ST_SWITCH;
                        end
                    end else begin
                        r_sw_cnt <= r_sw_cnt + SW'(1);
                    end
                end
                ST_OFFER: begin
                    if (grant_ack) begin
                        r_state       <= ST_XFER;
                        r_grant_valid <= 1'b0;
                        r_busy        <= 1'b1;
                    end else begin
                        r_state <= ST_OFFER;
                    end
                end
                ST_XFER: begin
                    if (line_done) begin
                        r_state    <= ST_ARB;
                        r_busy     <= 1'b0;
                        r_last_sel <= r_grant_sel;
                        if (r_grant_sel != r_last_sel) begin
                            r_consec <= CW'(1);
                        end else if (r_consec == CW'(MAX_CONSEC)) begin
                            r_consec <= r_consec;
                        end else begin
                            r_consec <= r_consec + CW'(1);
                        end
`ifdef LOCKSTEP_EN
                        r_due <= ~r_grant_sel;
`endif
                    end else begin
                        r_state <= ST_XFER;
                    end
                end
                default: begin
                    r_state       <= ST_IDLE;
                    r_grant_valid <= 1'b0;
                    r_busy        <= 1'b0;
                end
            endcase
        end
    end

    assign grant_valid = r_grant_valid;
    assign grant_sel   = r_grant_sel;
    assign busy        = r_busy;
    assign line_num    = r_line_num;
    assign frame_end   = w_wrap_r | w_wrap_l;

endmodule

// File: tb/tb_usb_line_arbiter.sv
// Scoreboard bench for usb_line_arbiter with a short line (WORDS=9) and IM_Y=4;
// expected grants are queued before stimulus and popped as each grant appears.
module tb_usb_line_arbiter;

    localparam int SW_LAT = 6;
    localparam int XW     = 5;

    typedef struct {
        logic        sel;
        logic [15:0] num;
        logic        fe;
    } exp_t;

    logic          USB_CLK = 1'b0;
    logic          rst_n;
    logic          start_stream;
    logic [XW-1:0] usedw_r;
    logic [XW-1:0] usedw_l;
    logic          dma_ready;
    logic          grant_valid;
    logic          grant_sel;
    logic          grant_ack;
    logic          line_done;
    logic [15:0]   line_num;
    logic          frame_end;
    logic          busy;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb[$];

    usb_line_arbiter #(
        .IM_X(8), .IM_Y(4), .COLOR_MODE(2), .MAX_CONSEC(2), .SW_LAT(SW_LAT)
    ) dut (
        .USB_CLK      (USB_CLK),
        .rst_n        (rst_n),
        .start_stream (start_stream),
        .usedw_r      (usedw_r),
        .usedw_l      (usedw_l),
        .dma_ready    (dma_ready),
        .grant_valid  (grant_valid),
        .grant_sel    (grant_sel),
        .grant_ack    (grant_ack),
        .line_done    (line_done),
        .line_num     (line_num),
        .frame_end    (frame_end),
        .busy         (busy)
    );

    always #5 USB_CLK = ~USB_CLK;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge USB_CLK);
        #1;
    endtask

    task automatic wait_grant(output int n);
        n = 0;
        while (!grant_valid && n < 200) begin
            tick();
            n++;
        end
    endtask

    task automatic stop_stream();
        start_stream = 1'b0;
        tick();
        tick();
    endtask

    // Waits for a grant, checks it against the scoreboard head, then runs the line.
    task automatic run_line();
        int   n;
        exp_t e;
        wait_grant(n);
        check_eq("grant_seen", grant_valid, 1'b1);
        if (sb.size() == 0) begin
            check_eq("sb_nonempty", 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            check_eq("grant_sel", grant_sel, e.sel);
            check_eq("line_num", line_num, e.num);
            grant_ack = 1'b1;
            tick();
            grant_ack = 1'b0;
            check_eq("busy_on", busy, 1'b1);
            check_eq("valid_off", grant_valid, 1'b0);
            tick();
            tick();
            line_done = 1'b1;
            tick();
            line_done = 1'b0;
            check_eq("frame_end", frame_end, e.fe);
            check_eq("busy_off", busy, 1'b0);
            tick();
            check_eq("frame_end_pulse", frame_end, 1'b0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst_n        = 1'b0;
        start_stream = 1'b0;
        usedw_r      = 5'd0;
        usedw_l      = 5'd0;
        dma_ready    = 1'b1;
        grant_ack    = 1'b0;
        line_done    = 1'b0;
        tick();
        tick();
        check_eq("rst_valid", grant_valid, 1'b0);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_sel", grant_sel, 1'b0);
        check_eq("rst_num", line_num, 16'd0);
        check_eq("rst_fe", frame_end, 1'b0);
        rst_n = 1'b1;
        tick();

`ifdef LOCKSTEP_EN
        // Only left ready: nothing may be granted until right is ready.
        usedw_l      = 5'd9;
        start_stream = 1'b1;
        n = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (grant_valid) n++;
        end
        check_eq("ls_no_grant", n, 0);
        usedw_r = 5'd9;
        for (int i = 0; i < 4; i++) begin
            sb.push_back('{1'b0, 16'(i), (i == 3)});
            sb.push_back('{1'b1, 16'(i), (i == 3)});
        end
        for (int i = 0; i < 8; i++) run_line();
        stop_stream();
`else
        // Only right ready: immediate offer, no switch guard.
        usedw_r      = 5'd8;
        start_stream = 1'b1;
        wait_grant(n);
        check_eq("t1_latency", n, 2);
        sb.push_back('{1'b0, 16'd0, 1'b0});
        run_line();
        sb.push_back('{1'b0, 16'd1, 1'b0});
        run_line();
        stop_stream();

        // Tie with last_sel=R: switch to left, guard lasts SW_LAT cycles.
        usedw_r      = 5'd9;
        usedw_l      = 5'd9;
        start_stream = 1'b1;
        for (int i = 0; i < 50 && grant_sel != 1'b1; i++) tick();
        check_eq("t2_sel_switched", grant_sel, 1'b1);
        check_eq("t2_no_early_offer", grant_valid, 1'b0);
        n = 0;
        while (!grant_valid && n < 50) begin
            tick();
            n++;
        end
        check_eq("t2_switch_len", n, SW_LAT);
        sb.push_back('{1'b1, 16'd0, 1'b0});
        run_line();
        stop_stream();

        // Right fuller, both ready: MAX_CONSEC caps the run at two.
        usedw_r      = 5'd12;
        usedw_l      = 5'd9;
        start_stream = 1'b1;
        sb.push_back('{1'b0, 16'd0, 1'b0});
        sb.push_back('{1'b0, 16'd1, 1'b0});
        sb.push_back('{1'b1, 16'd0, 1'b0});
        for (int i = 0; i < 3; i++) run_line();
        stop_stream();

        // Four right lines wrap the frame; the fifth starts again at 0.
        usedw_r      = 5'd9;
        usedw_l      = 5'd0;
        start_stream = 1'b1;
        for (int i = 0; i < 5; i++) sb.push_back('{1'b0, 16'(i % 4), (i == 3)});
        for (int i = 0; i < 5; i++) run_line();
        stop_stream();

        // Stop coincident with the wrapping line_done: stop wins.
        start_stream = 1'b1;
        for (int i = 0; i < 3; i++) sb.push_back('{1'b0, 16'(i), 1'b0});
        for (int i = 0; i < 3; i++) run_line();
        wait_grant(n);
        check_eq("t5_num", line_num, 16'd3);
        grant_ack = 1'b1;
        tick();
        grant_ack = 1'b0;
        tick();
        line_done    = 1'b1;
        start_stream = 1'b0;
        tick();
        line_done = 1'b0;
        check_eq("t5_busy", busy, 1'b0);
        check_eq("t5_valid", grant_valid, 1'b0);
        check_eq("t5_fe", frame_end, 1'b0);
        check_eq("t5_sel_hold", grant_sel, 1'b0);
        tick();
        check_eq("t5_fe_later", frame_end, 1'b0);
        start_stream = 1'b1;
        sb.push_back('{1'b0, 16'd0, 1'b0});
        run_line();

        // line_done during OFFER and grant_ack while idle are ignored.
        wait_grant(n);
        line_done = 1'b1;
        tick();
        line_done = 1'b0;
        check_eq("ign_done_busy", busy, 1'b0);
        check_eq("ign_done_valid", grant_valid, 1'b1);
        sb.push_back('{1'b0, 16'd1, 1'b0});
        run_line();
        stop_stream();
        grant_ack = 1'b1;
        tick();
        grant_ack = 1'b0;
        check_eq("ign_ack_busy", busy, 1'b0);
`endif

        // Async reset in the middle of a transfer.
        usedw_r      = 5'd9;
        usedw_l      = 5'd9;
        start_stream = 1'b1;
        wait_grant(n);
        check_eq("ar_grant", grant_valid, 1'b1);
        grant_ack = 1'b1;
        tick();
        grant_ack = 1'b0;
        check_eq("ar_busy", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        check_eq("ar_busy_clr", busy, 1'b0);
        check_eq("ar_valid_clr", grant_valid, 1'b0);
        check_eq("ar_sel_clr", grant_sel, 1'b0);
        check_eq("ar_num_clr", line_num, 16'd0);
        tick();
        rst_n = 1'b1;
        tick();
        wait_grant(n);
        check_eq("ar_regrant", grant_valid, 1'b1);
        check_eq("ar_num_after", line_num, 16'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
